dmem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port data memory (32 x 32-bit, combinational read, write on posedge) between N_REQ requesters, such as the core load/store unit and a DMA/debug port. It accepts one access per cycle, drives the memory's WE/A/WD, and returns a registered response one cycle later. An optional lock gives a requester back-to-back bursts, capped so other requesters cannot starve.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_arbiter_rr_pick.sv | 31 +++
 rtl/dmem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, default depth and arbiter state type for the data-memory arbiter
package dmem_pkg;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int DEPTH_DEF = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rtl/dmem_arbiter_rr_pick.sv - combinational round-robin priority encoder (first request at or after ptr_i)
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   int cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= N) cand = cand - N;
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter with capped lock bursts for a single-port data memory.
// Optional per-requester grant counters and starvation flags under DMEM_ARB_STATS_EN.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        lock,
   input  logic [N_REQ-1:0]        we,
   input  logic [N_REQ*ADDR_W-1:0] addr,
   input  logic [N_REQ*DATA_W-1:0] wdata,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]       rdata,
   output logic                    rerr,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_a,
   output logic [DATA_W-1:0]       mem_wd,
   input  logic [DATA_W-1:0]       mem_rd
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]     grant_cnt,
   output logic [N_REQ-1:0]        starve_flag
`endif
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [CNT_W-1:0] burst_inc;

   logic [N_REQ-1:0]  rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rerr_q;
   logic [ADDR_W-1:0] mem_a_q;
   logic [DATA_W-1:0] mem_wd_q;

   logic [N_REQ-1:0]  pick_oh;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_vld;

   logic [N_REQ-1:0]  gnt_raw;
   logic [IDX_W-1:0]  win_idx;
   logic              grant_any;
   logic              grant_ok;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              in_range;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      if (int'(i) == N_REQ - 1) return '0;
      return i + IDX_W'(1);
   endfunction

   rr_pick #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_oh),
      .idx_o   (pick_idx),
      .valid_o (pick_vld)
   );

   assign burst_inc = burst_cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      gnt_raw     = '0;
      win_idx     = owner_q;
      grant_any   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_raw   = pick_oh;
               win_idx   = pick_idx;
               grant_any = 1'b1;
               rr_ptr_d  = wrap_inc(pick_idx);
               if (lock[pick_idx] && (MAX_BURST > 1)) begin
                  state_d     = OWNED;
                  owner_d     = pick_idx;
                  burst_cnt_d = CNT_W'(1);
               end
            end
         end
         OWNED: begin
            // Owner dropping req forfeits the lock; the idle cycle is not handed to others.
            if (req[owner_q]) begin
               gnt_raw[owner_q] = 1'b1;
               grant_any        = 1'b1;
               burst_cnt_d      = burst_inc;
               if (!lock[owner_q] || (burst_inc >= CNT_W'(MAX_BURST))) begin
                  state_d = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grants are gated by reset so nothing reaches the memory while rst is low.
   assign grant_ok  = grant_any & rst;
   assign gnt       = rst ? gnt_raw : '0;
   assign win_addr  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign win_wdata = wdata[int'(win_idx)*DATA_W +: DATA_W];
   assign in_range  = (win_addr < ADDR_W'(DEPTH));

   assign mem_we = grant_ok & we[win_idx] & in_range;
   assign mem_a  = grant_ok ? win_addr  : mem_a_q;
   assign mem_wd = grant_ok ? win_wdata : mem_wd_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         rvalid_q    <= '0;
         rdata_q     <= '0;
         rerr_q      <= 1'b0;
         mem_a_q     <= '0;
         mem_wd_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         rvalid_q    <= gnt;
         if (grant_ok) begin
            rdata_q  <= in_range ? mem_rd : '0;
            rerr_q   <= ~in_range;
            mem_a_q  <= win_addr;
            mem_wd_q <= win_wdata;
         end
      end
   end

   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign rerr   = rerr_q;

`ifdef DMEM_ARB_STATS_EN
   localparam int STARVE_LIM = N_REQ * MAX_BURST;

   logic [N_REQ*16-1:0] grant_cnt_q;
   logic [N_REQ*16-1:0] wait_cnt_q;
   logic [N_REQ-1:0]    starve_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_cnt_q <= '0;
         wait_cnt_q  <= '0;
         starve_q    <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i] && (grant_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
               grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16] + 16'd1;
            end
            if (req[i] && !gnt[i]) begin
               if (wait_cnt_q[i*16 +: 16] != 16'hFFFF) begin
                  wait_cnt_q[i*16 +: 16] <= wait_cnt_q[i*16 +: 16] + 16'd1;
               end
               if (wait_cnt_q[i*16 +: 16] >= 16'(STARVE_LIM)) begin
                  starve_q[i] <= 1'b1;
               end
            end else begin
               wait_cnt_q[i*16 +: 16] <= '0;
            end
         end
      end
   end

   assign grant_cnt   = grant_cnt_q;
   assign starve_flag = starve_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural 32-word memory
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  lock;
   logic [1:0]  we;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [31:0] rdata;
   logic        rerr;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
`ifdef DMEM_ARB_STATS_EN
   logic [31:0] grant_cnt;
   logic [1:0]  starve_flag;
`endif

   logic [31:0] mem [0:31];

   int checks;
   int errors;

   dmem_arbiter #(
      .N_REQ     (2),
      .DEPTH     (32),
      .MAX_BURST (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .lock   (lock),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .gnt    (gnt),
      .rvalid (rvalid),
      .rdata  (rdata),
      .rerr   (rerr),
      .mem_we (mem_we),
      .mem_a  (mem_a),
      .mem_wd (mem_wd),
      .mem_rd (mem_rd)
`ifdef DMEM_ARB_STATS_EN
      ,
      .grant_cnt   (grant_cnt),
      .starve_flag (starve_flag)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory ignores upper address bits, so a leaked out-of-range write would alias.
   assign mem_rd = mem[mem_a[4:0]];
   always @(posedge clk) begin
      if (mem_we) mem[mem_a[4:0]] <= mem_wd;
   end

   task automatic idle_inputs();
      req   = 2'b00;
      lock  = 2'b00;
      we    = 2'b00;
      addr  = '0;
      wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      req = 2'b11;
      #1;
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
      checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL reset_rerr got=%b exp=0", rerr); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_read();
      @(negedge clk);
      req = 2'b01; we = 2'b00; addr[31:0] = 32'd5;
      #1;
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rd_gnt got=%b exp=01", gnt); end
      checks++; if (mem_a !== 32'd5) begin errors++; $display("FAIL rd_mem_a got=%h exp=5", mem_a); end
      @(posedge clk); #1;
      req = 2'b00;
      checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL rd_rvalid got=%b exp=01", rvalid); end
      checks++; if (rdata !== 32'd5) begin errors++; $display("FAIL rd_rdata got=%h exp=5", rdata); end
      checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL rd_rerr got=%b exp=0", rerr); end
      @(posedge clk); #1;
      checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rd_rvalid_once got=%b exp=00", rvalid); end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      req = 2'b01; we = 2'b01; addr[31:0] = 32'd3; wdata[31:0] = 32'hDEADBEEF;
      #1;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we got=%b exp=1", mem_we); end
      checks++; if (mem_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem_wd got=%h exp=deadbeef", mem_wd); end
      @(posedge clk); #1;
      we = 2'b00;
      checks++; if (rvalid !== 2'b01 || rdata !== 32'd3) begin errors++; $display("FAIL wr_old_word got=%b/%h exp=01/3", rvalid, rdata); end
      #1;
      checks++; if (gnt !== 2'b01 || mem_we !== 1'b0) begin errors++; $display("FAIL rb_gnt got=%b/%b exp=01/0", gnt, mem_we); end
      @(posedge clk); #1;
      req = 2'b00; addr[31:0] = 32'd9;
      checks++; if (rvalid !== 2'b01 || rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rb_new_word got=%b/%h exp=01/deadbeef", rvalid, rdata); end
      #1;
      checks++; if (mem_a !== 32'd3 || mem_we !== 1'b0) begin errors++; $display("FAIL idle_hold got=%h/%b exp=3/0", mem_a, mem_we); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_g [0:3];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      do_reset();
      @(negedge clk);
      req = 2'b11; we = 2'b00; addr = {32'd8, 32'd7};
      #1;
      checks++; if (gnt !== exp_g[0]) begin errors++; $display("FAIL rr_gnt0 got=%b exp=%b", gnt, exp_g[0]); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i == 3) req = 2'b00;
         checks++; if (rvalid !== exp_g[i]) begin errors++; $display("FAIL rr_rvalid%0d got=%b exp=%b", i, rvalid, exp_g[i]); end
         checks++; if (rdata !== ((exp_g[i] == 2'b01) ? 32'd7 : 32'd8)) begin errors++; $display("FAIL rr_rdata%0d got=%h", i, rdata); end
         if (i < 3) begin
            checks++; if (gnt !== exp_g[i+1]) begin errors++; $display("FAIL rr_gnt%0d got=%b exp=%b", i + 1, gnt, exp_g[i+1]); end
         end
      end
   endtask

   task automatic test_lock_burst();
      logic [1:0] exp_g [0:4];
      int lat;
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01; exp_g[4] = 2'b10;
      lat = -1;
      do_reset();
      @(negedge clk);
      req = 2'b11; lock = 2'b01; we = 2'b00; addr = {32'd11, 32'd10};
      #1;
      checks++; if (gnt !== exp_g[0]) begin errors++; $display("FAIL lk_gnt0 got=%b exp=%b", gnt, exp_g[0]); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 4) begin req = 2'b00; lock = 2'b00; end
         checks++; if (rvalid !== exp_g[i]) begin errors++; $display("FAIL lk_rvalid%0d got=%b exp=%b", i, rvalid, exp_g[i]); end
         if (i < 4) begin
            checks++; if (gnt !== exp_g[i+1]) begin errors++; $display("FAIL lk_gnt%0d got=%b exp=%b", i + 1, gnt, exp_g[i+1]); end
            if (gnt[1] && lat < 0) lat = i + 1;
         end
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL lk_latency got=%0d exp=4", lat); end
      checks++; if (rdata !== 32'd11) begin errors++; $display("FAIL lk_rdata got=%h exp=b", rdata); end
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      req = 2'b10; we = 2'b10; addr = {32'd40, 32'd0}; wdata = {32'h12345678, 32'h0};
      #1;
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL oor_gnt got=%b exp=10", gnt); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL oor_mem_we got=%b exp=0", mem_we); end
      @(posedge clk); #1;
      idle_inputs();
      checks++; if (rvalid !== 2'b10 || rerr !== 1'b1) begin errors++; $display("FAIL oor_resp got=%b/%b exp=10/1", rvalid, rerr); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=0", rdata); end
      checks++; if (mem[8] !== 32'd8) begin errors++; $display("FAIL oor_mem_alias got=%h exp=8", mem[8]); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      @(negedge clk);
      req = 2'b11; lock = 2'b01; we = 2'b00; addr = {32'd2, 32'd1};
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL mb_pre_rvalid got=%b exp=01", rvalid); end
      rst = 1'b0;
      #1;
      checks++; if (gnt !== 2'b00 || rvalid !== 2'b00) begin errors++; $display("FAIL mb_in_reset got=%b/%b exp=00/00", gnt, rvalid); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mb_first_gnt got=%b exp=01", gnt); end
      checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL mb_no_stale got=%b exp=00", rvalid); end
      @(posedge clk); #1;
      idle_inputs();
      checks++; if (rvalid !== 2'b01 || rdata !== 32'd1) begin errors++; $display("FAIL mb_resp got=%b/%h exp=01/1", rvalid, rdata); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) mem[i] = i;
      rst = 1'b1;
      idle_inputs();
      #2 rst = 1'b0;
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_lock_burst();
      test_out_of_range();
      test_reset_mid_burst();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
